// File: rtl/pipe_cmp_unit.sv
// pipe_cmp_unit: pipelined signed/unsigned comparator and branch-condition evaluator.
// Operands are resolved MSB-first, one CHUNK_WIDTH slice per stage. The last slice is
// folded straight into the result register, so accept->out_valid is NUM_STAGES cycles.
// A single global advance signal shifts every stage; flush clears all valid bits.
module pipe_cmp_unit #(
  parameter int DATA_WIDTH  = 64,
  parameter int CHUNK_WIDTH = 16,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_flush,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_numA,
  input  logic [DATA_WIDTH-1:0] in_numB,
  input  logic [2:0]            in_op,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [4:0]            out_flag,
  output logic                  out_result,
  output logic                  out_illegal,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_busy
);

  localparam int NUM_STAGES = DATA_WIDTH / CHUNK_WIDTH;

  logic                   r_out_valid;
  logic [4:0]             r_out_flag;
  logic                   r_out_result;
  logic                   r_out_illegal;
  logic [TAG_WIDTH-1:0]   r_out_tag;

  logic                   w_adv;
  logic                   w_load;
  logic [NUM_STAGES-1:0]  w_stg_vld;

  // Inputs to the final (result) stage: carried state plus the last operand slice.
  logic                   w_lst_vld;
  logic                   w_lst_eq;
  logic                   w_lst_ltu;
  logic                   w_lst_sa;
  logic                   w_lst_sb;
  logic [2:0]             w_lst_op;
  logic [TAG_WIDTH-1:0]   w_lst_tag;
  logic [CHUNK_WIDTH-1:0] w_lst_a;
  logic [CHUNK_WIDTH-1:0] w_lst_b;

  // Global stall: everything moves only when the output slot is free or being taken.
  assign w_adv     = ~r_out_valid | in_ready;
  assign out_ready = w_adv & ~in_flush;
  assign w_load    = in_valid & out_ready;

  generate
    if (NUM_STAGES == 1) begin : g_single
      assign w_lst_vld = w_load;
      assign w_lst_eq  = 1'b1;
      assign w_lst_ltu = 1'b0;
      assign w_lst_sa  = in_numA[DATA_WIDTH-1];
      assign w_lst_sb  = in_numB[DATA_WIDTH-1];
      assign w_lst_op  = in_op;
      assign w_lst_tag = in_tag;
      assign w_lst_a   = in_numA;
      assign w_lst_b   = in_numB;
    end else begin : g_multi
      for (genvar gi = 0; gi < NUM_STAGES - 1; gi++) begin : g_stg
        // Each stage keeps only the operand slices still to be examined.
        localparam int IN_W  = DATA_WIDTH - gi * CHUNK_WIDTH;
        localparam int REM_W = IN_W - CHUNK_WIDTH;

        logic                   w_vld_in;
        logic                   w_eq_in;
        logic                   w_ltu_in;
        logic                   w_sa_in;
        logic                   w_sb_in;
        logic [2:0]             w_op_in;
        logic [TAG_WIDTH-1:0]   w_tag_in;
        logic [IN_W-1:0]        w_a_in;
        logic [IN_W-1:0]        w_b_in;
        logic [CHUNK_WIDTH-1:0] w_sl_a;
        logic [CHUNK_WIDTH-1:0] w_sl_b;

        logic                   r_vld;
        logic                   r_eq;
        logic                   r_ltu;
        logic                   r_sa;
        logic                   r_sb;
        logic [2:0]             r_op;
        logic [TAG_WIDTH-1:0]   r_tag;
        logic [REM_W-1:0]       r_a;
        logic [REM_W-1:0]       r_b;

        if (gi == 0) begin : g_src
          assign w_vld_in = w_load;
          assign w_eq_in  = 1'b1;
          assign w_ltu_in = 1'b0;
          assign w_sa_in  = in_numA[DATA_WIDTH-1];
          assign w_sb_in  = in_numB[DATA_WIDTH-1];
          assign w_op_in  = in_op;
          assign w_tag_in = in_tag;
          assign w_a_in   = in_numA;
          assign w_b_in   = in_numB;
        end else begin : g_src
          assign w_vld_in = g_stg[gi-1].r_vld;
          assign w_eq_in  = g_stg[gi-1].r_eq;
          assign w_ltu_in = g_stg[gi-1].r_ltu;
          assign w_sa_in  = g_stg[gi-1].r_sa;
          assign w_sb_in  = g_stg[gi-1].r_sb;
          assign w_op_in  = g_stg[gi-1].r_op;
          assign w_tag_in = g_stg[gi-1].r_tag;
          assign w_a_in   = g_stg[gi-1].r_a;
          assign w_b_in   = g_stg[gi-1].r_b;
        end

        assign w_sl_a = w_a_in[IN_W-1 -: CHUNK_WIDTH];
        assign w_sl_b = w_b_in[IN_W-1 -: CHUNK_WIDTH];
        assign w_stg_vld[gi] = r_vld;

        // Resolve this slice; once a higher slice differed the verdict is frozen.
        always_ff @(posedge in_clk or negedge in_rst_n) begin
          if (!in_rst_n) begin
            r_vld <= 1'b0;
            r_eq  <= 1'b0;
            r_ltu <= 1'b0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_op  <= 3'b000;
            r_tag <= '0;
            r_a   <= '0;
            r_b   <= '0;
          end else if (in_flush) begin
            r_vld <= 1'b0;
          end else if (w_adv) begin
            r_vld <= w_vld_in;
            r_eq  <= w_eq_in & (w_sl_a == w_sl_b);
            r_ltu <= w_eq_in ? (w_sl_a < w_sl_b) : w_ltu_in;
            r_sa  <= w_sa_in;
            r_sb  <= w_sb_in;
            r_op  <= w_op_in;
            r_tag <= w_tag_in;
            r_a   <= w_a_in[REM_W-1:0];
            r_b   <= w_b_in[REM_W-1:0];
          end
        end
      end

      assign w_lst_vld = g_stg[NUM_STAGES-2].r_vld;
      assign w_lst_eq  = g_stg[NUM_STAGES-2].r_eq;
      assign w_lst_ltu = g_stg[NUM_STAGES-2].r_ltu;
      assign w_lst_sa  = g_stg[NUM_STAGES-2].r_sa;
      assign w_lst_sb  = g_stg[NUM_STAGES-2].r_sb;
      assign w_lst_op  = g_stg[NUM_STAGES-2].r_op;
      assign w_lst_tag = g_stg[NUM_STAGES-2].r_tag;
      assign w_lst_a   = g_stg[NUM_STAGES-2].r_a;
      assign w_lst_b   = g_stg[NUM_STAGES-2].r_b;
    end
  endgenerate

  assign w_stg_vld[NUM_STAGES-1] = r_out_valid;

  logic       w_fin_eq;
  logic       w_fin_ltu;
  logic       w_fin_lt;
  logic [4:0] w_fin_flag;
  logic       w_fin_res;
  logic       w_fin_ill;

  assign w_fin_eq   = w_lst_eq & (w_lst_a == w_lst_b);
  assign w_fin_ltu  = w_lst_eq ? (w_lst_a < w_lst_b) : w_lst_ltu;
  assign w_fin_lt   = (w_lst_sa != w_lst_sb) ? w_lst_sa : w_fin_ltu;
  assign w_fin_flag = {w_fin_eq, w_fin_lt, w_fin_ltu, ~w_fin_lt, ~w_fin_ltu};

  // Select the branch condition; encodings 010/011 are illegal and never taken.
  always_comb begin
    w_fin_res = 1'b0;
    w_fin_ill = 1'b0;
    case (w_lst_op)
      3'b000:  w_fin_res = w_fin_eq;
      3'b001:  w_fin_res = ~w_fin_eq;
      3'b100:  w_fin_res = w_fin_lt;
      3'b101:  w_fin_res = ~w_fin_lt;
      3'b110:  w_fin_res = w_fin_ltu;
      3'b111:  w_fin_res = ~w_fin_ltu;
      default: w_fin_ill = 1'b1;
    endcase
  end

  // Result register: loads on advance, holds while the consumer stalls.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_flag    <= 5'b00000;
      r_out_result  <= 1'b0;
      r_out_illegal <= 1'b0;
      r_out_tag     <= '0;
    end else if (in_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_lst_vld;
      if (w_lst_vld) begin
        r_out_flag    <= w_fin_flag;
        r_out_result  <= w_fin_res;
        r_out_illegal <= w_fin_ill;
        r_out_tag     <= w_lst_tag;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_flag    = r_out_flag;
  assign out_result  = r_out_result;
  assign out_illegal = r_out_illegal;
  assign out_tag     = r_out_tag;
  assign out_busy    = |w_stg_vld;

endmodule

// File: tb/tb_pipe_cmp_unit.sv
// Scoreboard bench for pipe_cmp_unit: a 64/16 instance and a 32/8 instance.
module tb_pipe_cmp_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 64-bit instance (wd_) and 32-bit instance (nr_)
  logic        wd_flush, wd_valid, wd_oready, wd_ovalid, wd_iready;
  logic [63:0] wd_a, wd_b;
  logic [2:0]  wd_op;
  logic [4:0]  wd_tag, wd_flag, wd_otag;
  logic        wd_res, wd_ill, wd_busy;

  logic        nr_flush, nr_valid, nr_oready, nr_ovalid, nr_iready;
  logic [31:0] nr_a, nr_b;
  logic [2:0]  nr_op;
  logic [4:0]  nr_tag, nr_flag, nr_otag;
  logic        nr_res, nr_ill, nr_busy;

  pipe_cmp_unit #(.DATA_WIDTH(64), .CHUNK_WIDTH(16), .TAG_WIDTH(5)) u_wd (
    .in_clk(clk), .in_rst_n(rst_n), .in_flush(wd_flush), .in_valid(wd_valid),
    .out_ready(wd_oready), .in_numA(wd_a), .in_numB(wd_b), .in_op(wd_op),
    .in_tag(wd_tag), .out_valid(wd_ovalid), .in_ready(wd_iready), .out_flag(wd_flag),
    .out_result(wd_res), .out_illegal(wd_ill), .out_tag(wd_otag), .out_busy(wd_busy)
  );

  pipe_cmp_unit #(.DATA_WIDTH(32), .CHUNK_WIDTH(8), .TAG_WIDTH(5)) u_nr (
    .in_clk(clk), .in_rst_n(rst_n), .in_flush(nr_flush), .in_valid(nr_valid),
    .out_ready(nr_oready), .in_numA(nr_a), .in_numB(nr_b), .in_op(nr_op),
    .in_tag(nr_tag), .out_valid(nr_ovalid), .in_ready(nr_iready), .out_flag(nr_flag),
    .out_result(nr_res), .out_illegal(nr_ill), .out_tag(nr_otag), .out_busy(nr_busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] tag;
    logic [4:0] flag;
    logic       res;
    logic       ill;
  } exp_t;

  exp_t q_wd[$];
  exp_t q_nr[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitors: compare every result the consumer takes against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && wd_ovalid && wd_iready) begin
      exp_t e;
      checks++;
      if (q_wd.size() == 0) begin
        errors++;
        $display("FAIL wd_unexpected: got tag=%0d flag=%b, expected no result", wd_otag, wd_flag);
      end else begin
        e = q_wd.pop_front();
        if ({wd_otag, wd_flag, wd_res, wd_ill} !== e) begin
          errors++;
          $display("FAIL wd_result: got tag=%0d flag=%b res=%b ill=%b, expected tag=%0d flag=%b res=%b ill=%b",
                   wd_otag, wd_flag, wd_res, wd_ill, e.tag, e.flag, e.res, e.ill);
        end else begin
          $display("wd tag=%0d flag=%b res=%b ill=%b ok", wd_otag, wd_flag, wd_res, wd_ill);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && nr_ovalid && nr_iready) begin
      exp_t e;
      checks++;
      if (q_nr.size() == 0) begin
        errors++;
        $display("FAIL nr_unexpected: got tag=%0d flag=%b, expected no result", nr_otag, nr_flag);
      end else begin
        e = q_nr.pop_front();
        if ({nr_otag, nr_flag, nr_res, nr_ill} !== e) begin
          errors++;
          $display("FAIL nr_result: got tag=%0d flag=%b res=%b ill=%b, expected tag=%0d flag=%b res=%b ill=%b",
                   nr_otag, nr_flag, nr_res, nr_ill, e.tag, e.flag, e.res, e.ill);
        end else begin
          $display("nr tag=%0d flag=%b res=%b ill=%b ok", nr_otag, nr_flag, nr_res, nr_ill);
        end
      end
    end
  end

  // Present one op, wait for acceptance, optionally record the expected result.
  task automatic send(input bit narrow, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] op, input logic [4:0] tag, input logic [4:0] flag,
                      input logic res, input logic ill, input bit push);
    int guard;
    guard = 0;
    @(negedge clk);
    if (!narrow) begin
      wd_a = a; wd_b = b; wd_op = op; wd_tag = tag; wd_valid = 1'b1;
    end else begin
      nr_a = a[31:0]; nr_b = b[31:0]; nr_op = op; nr_tag = tag; nr_valid = 1'b1;
    end
    while (((!narrow && !wd_oready) || (narrow && !nr_oready)) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: out_ready stayed 0 for tag %0d, expected 1", tag);
    end else if (push) begin
      if (!narrow) q_wd.push_back({tag, flag, res, ill});
      else         q_nr.push_back({tag, flag, res, ill});
    end
    @(posedge clk);
    #1;
    wd_valid = 1'b0;
    nr_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q_wd.size() != 0 || q_nr.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", 64'(q_wd.size() + q_nr.size()), 64'd0);
  endtask

  // Three ops in flight, flush (with a same-cycle request), nothing may emerge.
  task automatic flush_test(input bit narrow, input logic [4:0] t0);
    for (int i = 0; i < 3; i++)
      send(narrow, 64'd10 + 64'(i), 64'd3, 3'b000, 5'(t0 + 5'(i)), 5'd0, 1'b0, 1'b0, 1'b0);
    if (!narrow) begin
      wd_flush = 1'b1; wd_valid = 1'b1; wd_tag = t0 + 5'd3;
    end else begin
      nr_flush = 1'b1; nr_valid = 1'b1; nr_tag = t0 + 5'd3;
    end
    @(negedge clk);
    chk(narrow ? "nr_flush_oready" : "wd_flush_oready", narrow ? nr_oready : wd_oready, 64'd0);
    @(posedge clk);
    #1;
    wd_flush = 1'b0; nr_flush = 1'b0; wd_valid = 1'b0; nr_valid = 1'b0;
    chk(narrow ? "nr_flush_ovalid" : "wd_flush_ovalid", narrow ? nr_ovalid : wd_ovalid, 64'd0);
    chk(narrow ? "nr_flush_busy" : "wd_flush_busy", narrow ? nr_busy : wd_busy, 64'd0);
    repeat (8) @(negedge clk);
    chk(narrow ? "nr_flush_busy_late" : "wd_flush_busy_late", narrow ? nr_busy : wd_busy, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wd_flush = 0; wd_valid = 0; wd_a = 0; wd_b = 0; wd_op = 0; wd_tag = 0; wd_iready = 1;
    nr_flush = 0; nr_valid = 0; nr_a = 0; nr_b = 0; nr_op = 0; nr_tag = 0; nr_iready = 1;
    #1;
    chk("rst_wd_ovalid", wd_ovalid, 0);
    chk("rst_wd_flag", wd_flag, 0);
    chk("rst_wd_busy", wd_busy, 0);
    chk("rst_nr_ovalid", nr_ovalid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_wd_oready", wd_oready, 1);
    chk("rst_nr_oready", nr_oready, 1);

    // 1: -1 < 1 signed; latency of four cycles
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100, 5'd1, 5'b01001, 1'b1, 1'b0, 1'b1);
    chk("lat_c0", wd_ovalid, 0);
    repeat (2) @(posedge clk);
    #1 chk("lat_c2", wd_ovalid, 0);
    @(posedge clk);
    #1 chk("lat_c3", wd_ovalid, 1);
    // 2: equal operands
    send(0, 64'd5, 64'd5, 3'b000, 5'd2, 5'b10011, 1'b1, 1'b0, 1'b1);
    send(0, 64'd5, 64'd5, 3'b001, 5'd3, 5'b10011, 1'b0, 1'b0, 1'b1);
    // 3: most negative vs most positive
    send(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b110, 5'd4, 5'b01001, 1'b0, 1'b0, 1'b1);
    // 4: difference only in the lowest slice; illegal op
    send(0, 64'h100, 64'h101, 3'b011, 5'd5, 5'b01100, 1'b0, 1'b1, 1'b1);
    send(0, 64'h100, 64'h101, 3'b110, 5'd6, 5'b01100, 1'b1, 1'b0, 1'b1);
    drain();

    // 5: eight back-to-back ops with a consumer stall
    fork
      begin
        send(0, 64'd3, 64'd7, 3'b100, 5'd10, 5'b01100, 1'b1, 1'b0, 1'b1);
        send(0, 64'd7, 64'd3, 3'b111, 5'd11, 5'b00011, 1'b1, 1'b0, 1'b1);
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 3'b100, 5'd12, 5'b00011, 1'b0, 1'b0, 1'b1);
        send(0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 5'd13, 5'b01100, 1'b1, 1'b0, 1'b1);
        send(0, 64'd0, 64'h8000_0000_0000_0000, 3'b101, 5'd14, 5'b00110, 1'b1, 1'b0, 1'b1);
        send(0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 3'b001, 5'd15, 5'b10011, 1'b0, 1'b0, 1'b1);
        send(0, 64'h1_0000_0000, 64'hFFFF_FFFF, 3'b110, 5'd16, 5'b00011, 1'b0, 1'b0, 1'b1);
        send(0, 64'd5, 64'd5, 3'b010, 5'd17, 5'b10011, 1'b0, 1'b1, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1 wd_iready = 1'b0;
        repeat (3) @(posedge clk);
        #1 wd_iready = 1'b1;
      end
      begin
        repeat (20) begin
          @(negedge clk);
          chk("stall_oready", wd_oready, !(wd_ovalid && !wd_iready));
        end
      end
    join
    drain();

    // 32/8 instance
    send(1, 64'hFFFF_FFFF, 64'd1, 3'b100, 5'd7, 5'b01001, 1'b1, 1'b0, 1'b1);
    send(1, 64'h80, 64'h80, 3'b000, 5'd8, 5'b10011, 1'b1, 1'b0, 1'b1);
    send(1, 64'h1, 64'h2, 3'b111, 5'd9, 5'b01100, 1'b0, 1'b0, 1'b1);
    drain();

    // 6: flush on both widths
    flush_test(0, 5'd20);
    flush_test(1, 5'd24);
    send(1, 64'h7FFF_FFFF, 64'h8000_0000, 3'b101, 5'd28, 5'b00110, 1'b1, 1'b0, 1'b1);
    drain();

    // Asynchronous reset while a result is held under stall
    wd_iready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100, 5'd25, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_ovalid", wd_ovalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ovalid", wd_ovalid, 0);
    chk("async_rst_flag", wd_flag, 0);
    chk("async_rst_result", wd_res, 0);
    chk("async_rst_illegal", wd_ill, 0);
    chk("async_rst_tag", wd_otag, 0);
    chk("async_rst_busy", wd_busy, 0);
    chk("async_rst_oready", wd_oready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wd_iready = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_busy", wd_busy, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
